// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider (DIV/DIVU) for the EX stage.
// The divider holds the upstream pipeline through stall_o while it runs.
// The quotient goes to LO and the remainder goes to HI.
// Optional feature macro: DIV_FAST_EN. When it is defined, a dividend whose
// magnitude is below the divisor's finishes at once, without iterating.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             annul_i,
    output logic             stall_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_q;        // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] r_rem;      // partial remainder (always < r_b)
    logic [WIDTH-1:0] r_b;        // divisor magnitude
    logic [CW-1:0]    r_cnt;      // iterations still to run
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_ready;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remo;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_fast;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quot_fin;
    logic [WIDTH-1:0] w_rem_fin;

    // Operand magnitudes. The most negative value maps to 2^(WIDTH-1) unsigned.
    assign w_a_mag = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    assign w_b_mag = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

`ifdef DIV_FAST_EN
    assign w_fast = (w_a_mag < w_b_mag);
`else
    assign w_fast = 1'b0;
`endif

    // A single restoring step. w_shift needs one extra bit because r_rem < r_b.
    // After a successful subtraction, the difference fits in WIDTH bits again.
    assign w_shift    = {r_rem, r_q[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_b};
    assign w_ge       = (w_shift >= {1'b0, r_b});
    assign w_rem_next = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_q_next   = {r_q[WIDTH-2:0], w_ge};

    // Sign fix-up. For -2^(W-1)/-1, the magnitude quotient 2^(W-1) is left un-negated.
    assign w_quot_fin = r_neg_q ? -w_q_next   : w_q_next;
    assign w_rem_fin  = r_neg_r ? -w_rem_next : w_rem_next;

    // Hold the pipeline from the accept cycle through the last iteration.
    assign stall_o = rst_n & ~annul_i &
                     (((r_state == S_IDLE) & start_i) | (r_state == S_BUSY));
    assign ready_o = r_ready;
    assign quot_o  = r_quot;
    assign rem_o   = r_remo;

    // Control FSM and datapath. Results are registered on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_rem   <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_ready <= 1'b0;
            r_quot  <= '0;
            r_remo  <= '0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i && !annul_i) begin
                        if (b_i == '0) begin
                            r_quot  <= '1;
                            r_remo  <= a_i;
                            r_ready <= 1'b1;
                            r_state <= S_DONE;
                        end else if (w_fast) begin
                            r_quot  <= '0;
                            r_remo  <= a_i;
                            r_ready <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_q     <= w_a_mag;
                            r_rem   <= '0;
                            r_b     <= w_b_mag;
                            r_cnt   <= CW'(WIDTH);
                            r_neg_q <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                            r_neg_r <= signed_i & a_i[WIDTH-1];
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (annul_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_q   <= w_q_next;
                        r_rem <= w_rem_next;
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1)) begin
                            r_quot  <= w_quot_fin;
                            r_remo  <= w_rem_fin;
                            r_ready <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed and random DIV/DIVU transactions, checked against
// an arithmetic reference model. Build with DIV_FAST_EN defined to cover
// the short path for small dividends.
module tb_div_iter;

    localparam int W = 32;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         start_i  = 1'b0;
    logic         signed_i = 1'b0;
    logic [W-1:0] a_i      = '0;
    logic [W-1:0] b_i      = '0;
    logic         annul_i  = 1'b0;
    logic         stall_o;
    logic         ready_o;
    logic [W-1:0] quot_o;
    logic [W-1:0] rem_o;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;

    div_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .signed_i(signed_i),
        .a_i(a_i), .b_i(b_i), .annul_i(annul_i), .stall_o(stall_o),
        .ready_o(ready_o), .quot_o(quot_o), .rem_o(rem_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    // Reference: plain integer division. Truncates toward zero; the remainder follows the dividend.
    function automatic void model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output int lat);
        longint sa, sb, qq, rr, ma, mb;
        sa = s ? longint'($signed(a)) : longint'({32'd0, a});
        sb = s ? longint'($signed(b)) : longint'({32'd0, b});
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        lat = W + 1;
        if (b == '0) begin
            q = '1;
            r = a;
            lat = 1;
        end else begin
            qq = sa / sb;
            rr = sa % sb;
            q = qq[W-1:0];
            r = rr[W-1:0];
`ifdef DIV_FAST_EN
            if (ma < mb) lat = 1;
`else
            if (ma < mb) lat = W + 1;
`endif
        end
    endfunction

    // A single transaction. It is driven on the negedge and sampled on the negedge.
    task automatic do_div(input string tag, input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eq, er;
        int lat, k, stalls;
        bit got;
        model(s, a, b, eq, er, lat);
        @(negedge clk);
        signed_i = s; a_i = a; b_i = b; start_i = 1'b1;
        #1;
        check({tag, "_stall_t0"}, 64'(stall_o), 64'(1));
        stalls = 1; k = 0; got = 1'b0;
        while (!got && k < 100) begin
            @(negedge clk);
            k++;
            a_i = $urandom; b_i = $urandom; signed_i = $urandom_range(0, 1);
            if (ready_o) got = 1'b1;
            else if (stall_o) stalls++;
        end
        check({tag, "_ready_seen"}, 64'(got), 64'(1));
        check({tag, "_stall_at_ready"}, 64'(stall_o), 64'(0));
        start_i = 1'b0;
        check({tag, "_latency"}, 64'(k), 64'(lat));
        check({tag, "_stall_cycles"}, 64'(stalls), 64'(lat));
        check({tag, "_quot"}, 64'(quot_o), 64'(eq));
        check({tag, "_rem"}, 64'(rem_o), 64'(er));
        $display("div %s s=%0d a=%h b=%h -> q=%h r=%h lat=%0d", tag, s, a, b, quot_o, rem_o, k);
        last_q = eq; last_r = er;
    endtask

    initial begin
        int pulses;
        logic [W-1:0] ra, rb;
        bit rs;
        // Reset state
        #1;
        check("rst_stall", 64'(stall_o), 64'(0));
        check("rst_ready", 64'(ready_o), 64'(0));
        check("rst_quot", 64'(quot_o), 64'(0));
        check("rst_rem", 64'(rem_o), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        do_div("divu_100_7", 1'b0, 32'd100, 32'd7);
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        do_div("divu_5_0", 1'b0, 32'd5, 32'd0);
        do_div("div_neg_0", 1'b1, 32'hFFFF_FF00, 32'd0);
        do_div("divu_3_10", 1'b0, 32'd3, 32'd10);
        do_div("div_m3_10", 1'b1, 32'hFFFF_FFFD, 32'd10);
        do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        do_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);

        // Annul in BUSY cycle 10: stall drops at once, with no result and outputs held
        @(negedge clk);
        signed_i = 1'b0; a_i = 32'd1000; b_i = 32'd3; start_i = 1'b1;
        for (int i = 0; i < 10; i++) @(negedge clk);
        annul_i = 1'b1;
        #1;
        check("annul_busy_stall", 64'(stall_o), 64'(0));
        pulses = 0;
        @(negedge clk);
        annul_i = 1'b0; start_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready_o) pulses++;
        end
        check("annul_busy_no_ready", 64'(pulses), 64'(0));
        check("annul_busy_quot_held", 64'(quot_o), 64'(last_q));
        check("annul_busy_rem_held", 64'(rem_o), 64'(last_r));
        do_div("divu_9_3", 1'b0, 32'd9, 32'd3);

        // start_i while annul_i is high in IDLE is not accepted
        @(negedge clk);
        a_i = 32'd77; b_i = 32'd0; start_i = 1'b1; annul_i = 1'b1;
        #1;
        check("annul_idle_stall", 64'(stall_o), 64'(0));
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ready_o) pulses++;
        end
        start_i = 1'b0; annul_i = 1'b0;
        check("annul_idle_no_ready", 64'(pulses), 64'(0));
        check("annul_idle_quot_held", 64'(quot_o), 64'(last_q));

        // Asynchronous reset in BUSY cycle 5
        @(negedge clk);
        signed_i = 1'b0; a_i = 32'd1234; b_i = 32'd5; start_i = 1'b1;
        for (int i = 0; i < 5; i++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_busy_stall", 64'(stall_o), 64'(0));
        check("rst_busy_ready", 64'(ready_o), 64'(0));
        check("rst_busy_quot", 64'(quot_o), 64'(0));
        check("rst_busy_rem", 64'(rem_o), 64'(0));
        @(negedge clk);
        start_i = 1'b0; rst_n = 1'b1;
        do_div("divu_50_5", 1'b0, 32'd50, 32'd5);

        // Random transactions, with divisor classes chosen to hit the boundary cases
        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = '0;
                1: rb = $urandom_range(1, 15);
                2: rb = $urandom;
                3: begin rb = $urandom; ra = ra >> $urandom_range(8, 31); end
                default: rb = 32'hFFFF_FFFF;
            endcase
            do_div($sformatf("rand%0d", i), rs, ra, rb);
        end

        // Results are held once the pulse is over
        for (int i = 0; i < 5; i++) @(negedge clk);
        check("hold_ready_low", 64'(ready_o), 64'(0));
        check("hold_quot", 64'(quot_o), 64'(last_q));
        check("hold_rem", 64'(rem_o), 64'(last_r));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
